// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        FLUSH
    } fetch_state_t;

    localparam int OPCODE_W        = 4;
    localparam int DEFAULT_PC_STEP = 4;

    // The opcode occupies the top OPCODE_W bits of an instruction word.
    function automatic int opcode_lsb(input int ilen);
        return ilen - OPCODE_W;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer used by the prefetching fetch build.
module fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;

    // NOTE: every sequential assignment uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too so the head reads zero out of reset; affordable only at two entries.
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/gnt/rvalid memory port, valid/ready to decode.
// Define FETCH_PREFETCH_EN for the 2-entry prefetch buffer build.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int             XLEN     = 32,
    parameter int             ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int             PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [ILEN-1:0]     imem_rdata,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    input  logic                id_ready,
    output logic                id_valid,
    output logic [ILEN-1:0]     id_instr,
    output logic [XLEN-1:0]     id_pc,
    output logic [OPCODE_W-1:0] id_opcode
);

    localparam int              OPCODE_LSB = opcode_lsb(ILEN);
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

    logic [XLEN-1:0] pc;

    assign imem_addr = pc;
    assign id_opcode = id_instr[OPCODE_LSB +: OPCODE_W];

`ifdef FETCH_PREFETCH_EN
    logic [1:0]           outstanding;
    logic [1:0]           drop_cnt;
    logic [1:0]           count;
    logic [1:0]           live;
    logic                 pop;
    logic                 push;
    logic [XLEN-1:0]      rsp_pc;
    logic [XLEN+ILEN-1:0] head;

    assign id_valid = (count != 2'd0);
    assign pop      = id_valid && id_ready && !redirect_valid;
    assign push     = imem_rvalid && (drop_cnt == 2'd0) && !redirect_valid;
    // Live requests were issued back to back, so the oldest sits live steps behind pc.
    assign live     = outstanding - drop_cnt;
    assign rsp_pc   = pc - STEP * XLEN'(live);
    // rst_n gates the request so nothing is issued while reset is held.
    assign imem_req = rst_n && !redirect_valid &&
                      ((3'(count) + 3'(outstanding) - 3'(pop)) < 3'd2);

    fetch_fifo #(.WIDTH(XLEN + ILEN)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({rsp_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign {id_pc, id_instr} = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            outstanding <= outstanding - 2'(imem_rvalid);
            drop_cnt    <= outstanding - 2'(imem_rvalid);
        end else begin
            if (imem_req && imem_gnt) begin
                pc <= pc + STEP;
            end
            outstanding <= outstanding + 2'(imem_req && imem_gnt) - 2'(imem_rvalid);
            if (imem_rvalid && drop_cnt != 2'd0) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
        end
    end
`else
    fetch_state_t    state;
    logic [XLEN-1:0] req_pc;
    logic            out_free;

    assign out_free = !id_valid || id_ready;
    // rst_n gates the request so nothing is issued while reset is held.
    assign imem_req = rst_n && (state == FETCH) && out_free && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            id_valid <= 1'b0;
            // A granted request that does not return this cycle must be drained.
            if (state != FETCH && !imem_rvalid) begin
                state <= FLUSH;
            end else begin
                state <= FETCH;
            end
        end else begin
            if (id_valid && id_ready) begin
                id_valid <= 1'b0;
            end
            case (state)
                FETCH: begin
                    if (imem_req && imem_gnt) begin
                        req_pc <= pc;
                        pc     <= pc + STEP;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        id_instr <= imem_rdata;
                        id_pc    <= req_pc;
                        id_valid <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FLUSH: begin
                    if (imem_rvalid) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit with a queue-based behavioural model.
`timescale 1ns/1ps
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [3:0]  id_opcode;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_opcode(id_opcode)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Stimulus knobs
    int          ready_pct = 100, gnt_pct = 100, lat_min = 1, lat_max = 1, redir_permille = 0;
    bit          scramble = 0;
    bit          trig_gnt_en = 0, trig_rv_en = 0;
    logic [31:0] trig_gnt_addr = '0, trig_target = '0;
    bit          redir_pend = 0;
    logic [31:0] redir_pend_pc = '0;
    int          redir_cyc = -1;
    int          req_cnt = 0;

    typedef struct { int cyc; logic [31:0] pc; logic [3:0] op; } hs_t;
    typedef struct { int cyc; logic [31:0] addr; } gnt_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;
    typedef struct { logic [31:0] addr; bit dropped; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    hs_t  hs_log[$];
    gnt_t gnt_log[$];
    bit   vld_log[$];
    mem_t memq[$];
    req_t outs[$];
    ent_t outq[$];
    logic [31:0] m_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (scramble) return {a[5:2] ^ a[9:6], a[27:0] ^ 28'h5A5A5A5};
        return {4'h8, a[27:0]};
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(3) << 2);
        return t;
    endfunction

    // Drive, compare against the model, then advance the model across the next edge.
    initial begin
        bit   pop, exp_req;
        req_t r;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                id_ready = 0; imem_rvalid = 0; imem_gnt = 0; redirect_valid = 0;
                memq.delete(); outs.delete(); outq.delete();
                hs_log.delete(); gnt_log.delete(); vld_log.delete();
                m_pc = 32'h0; cyc = 0; redir_pend = 0; redir_cyc = -1;
            end else begin
                id_ready = ($urandom_range(99) < ready_pct);
                imem_rvalid = 0;
                imem_rdata = $urandom;
                if (memq.size() > 0 && memq[0].due <= cyc) begin
                    imem_rvalid = 1;
                    imem_rdata = mem_word(memq[0].addr);
                    void'(memq.pop_front());
                end
                redirect_valid = 0;
                redirect_pc = $urandom;
                if (redir_pend) begin
                    redirect_valid = 1; redirect_pc = redir_pend_pc; redir_pend = 0; redir_cyc = cyc;
                end else if (trig_rv_en && imem_rvalid) begin
                    redirect_valid = 1; redirect_pc = trig_target; id_ready = 1;
                    trig_rv_en = 0; redir_cyc = cyc;
                end else if ($urandom_range(999) < redir_permille) begin
                    redirect_valid = 1; redirect_pc = rand_target();
                end
                #1;
                pop = (outq.size() > 0) && id_ready && !redirect_valid;
                exp_req = !redirect_valid &&
                          (int'(outq.size()) - int'(pop) + int'(outs.size()) < CAP);
                check("id_valid", id_valid, outq.size() > 0);
                if (outq.size() > 0) begin
                    check("id_pc", id_pc, outq[0].pc);
                    check("id_instr", id_instr, outq[0].instr);
                    check("id_opcode", id_opcode, outq[0].instr[31:28]);
                end
                check("imem_req", imem_req, exp_req);
                if (exp_req) check("imem_addr", imem_addr, m_pc);
                vld_log.push_back(id_valid);
                if (pop) hs_log.push_back('{cyc, id_pc, id_opcode});
                if (imem_req) req_cnt++;
                imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
                if (imem_gnt) begin
                    lat = $urandom_range(lat_max, lat_min);
                    memq.push_back('{imem_addr, cyc + lat});
                    gnt_log.push_back('{cyc, imem_addr});
                    if (trig_gnt_en && imem_addr == trig_gnt_addr) begin
                        redir_pend = 1; redir_pend_pc = trig_target; trig_gnt_en = 0;
                    end
                end
                if (redirect_valid) begin
                    outq.delete();
                    if (imem_rvalid && outs.size() > 0) void'(outs.pop_front());
                    foreach (outs[i]) outs[i].dropped = 1;
                    m_pc = redirect_pc;
                end else begin
                    if (pop) void'(outq.pop_front());
                    if (imem_rvalid && outs.size() > 0) begin
                        r = outs.pop_front();
                        if (!r.dropped) outq.push_back('{r.addr, mem_word(r.addr)});
                    end
                    if (exp_req && imem_gnt) begin
                        outs.push_back('{m_pc, 1'b0});
                        m_pc = m_pc + 32'd4;
                    end
                end
                cyc++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2; rst_n = 1'b0;
        #1;
        check("async_rst_id_valid", id_valid, 1'b0);
        check("async_rst_imem_req", imem_req, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        rst_n = 1'b1;
    endtask

    function automatic int first_hs_after(input int c);
        foreach (hs_log[i]) if (hs_log[i].cyc > c) return i;
        return -1;
    endfunction

    function automatic int first_gnt_after(input int c);
        foreach (gnt_log[i]) if (gnt_log[i].cyc > c) return i;
        return -1;
    endfunction

    initial begin
        int          k;
        int          req0;
        logic [31:0] pc0;
        int          n8;

        // Zero-wait memory, decode always ready
        do_reset();
        repeat (14) @(posedge clk);
        check("a_hs_count_ok", hs_log.size() >= 3, 1'b1);
        check("a_gnt_count_ok", gnt_log.size() >= 1, 1'b1);
        if (gnt_log.size() >= 1) begin
            check("a_first_req_cyc", gnt_log[0].cyc, 0);
            check("a_first_req_addr", gnt_log[0].addr, 32'h0);
        end
        if (hs_log.size() >= 3) begin
            check("a_first_valid_cyc", hs_log[0].cyc, 2);
            check("a_pc0", hs_log[0].pc, 32'h0);
            check("a_pc1", hs_log[1].pc, 32'h4);
            check("a_pc2", hs_log[2].pc, 32'h8);
            check("a_opcode", hs_log[1].op, 4'h8);
            check("a_rate", hs_log[1].cyc - hs_log[0].cyc, (CAP == 1) ? 2 : 1);
        end

        // Decode stalls for five cycles
        ready_pct = 0;
        repeat (3) @(negedge clk);
        #3;
        req0 = req_cnt;
        pc0 = id_pc;
        repeat (5) begin
            @(negedge clk); #3;
            check("b_stall_valid", id_valid, 1'b1);
            check("b_stall_pc", id_pc, pc0);
        end
        check("b_stall_no_req", req_cnt - req0, 0);

        // Redirect to 0x40 while the request to 0x8 is outstanding, 3-cycle memory
        ready_pct = 100; lat_min = 3; lat_max = 3;
        trig_gnt_addr = 32'h8; trig_target = 32'h40; trig_gnt_en = 1;
        do_reset();
        repeat (30) @(posedge clk);
        k = first_hs_after(redir_cyc);
        check("c_redirect_seen", (redir_cyc >= 0) && (k >= 0), 1'b1);
        if (k >= 0) check("c_next_pc", hs_log[k].pc, 32'h40);
        n8 = 0;
        foreach (hs_log[i]) if (hs_log[i].pc == 32'h8) n8++;
        check("c_dropped_8", n8, 0);

        // Redirect coinciding with a response and decode ready
        trig_gnt_en = 0; lat_min = 2; lat_max = 2;
        trig_target = 32'h40; trig_rv_en = 1;
        do_reset();
        repeat (12) @(posedge clk);
        check("d_redirect_seen", (redir_cyc >= 0) && (vld_log.size() > redir_cyc + 1), 1'b1);
        if (redir_cyc >= 0 && vld_log.size() > redir_cyc + 1)
            check("d_valid_cleared", vld_log[redir_cyc + 1], 1'b0);
        k = first_gnt_after(redir_cyc);
        if (k >= 0) check("d_next_addr", gnt_log[k].addr, 32'h40);
        else check("d_next_addr_present", 0, 1);

        // PC wrap at the top of the address space
        trig_rv_en = 0; lat_min = 1; lat_max = 1;
        trig_gnt_addr = 32'h8; trig_target = 32'hFFFF_FFFC; trig_gnt_en = 1;
        do_reset();
        repeat (16) @(posedge clk);
        k = first_gnt_after(redir_cyc);
        check("e_two_gnts", (redir_cyc >= 0) && (k >= 0) && (k + 1 < gnt_log.size()), 1'b1);
        if (k >= 0 && k + 1 < gnt_log.size()) begin
            check("e_addr_top", gnt_log[k].addr, 32'hFFFF_FFFC);
            check("e_addr_wrap", gnt_log[k + 1].addr, 32'h0);
        end

        // Randomized traffic with a mid-run asynchronous reset
        trig_gnt_en = 0; scramble = 1;
        ready_pct = 70; gnt_pct = 70; lat_min = 1; lat_max = 4; redir_permille = 40;
        do_reset();
        repeat (1500) @(posedge clk);
        do_reset();
        repeat (1500) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
